// File: rtl/cellrv32_icache_mem_pkg.sv
// Shared helpers for the instruction-cache storage core: geometry functions and
// the address-field width record used to split lookup/refill addresses.
package cellrv32_icache_mem_pkg;

    typedef struct packed {
        int tag_w;
        int idx_w;
        int ofs_w;
    } icache_addr_fields_t;

    function automatic int index_size_f(input int n);
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) >= n) return i;
        end
        return 32;
    endfunction

    function automatic bit is_power_of_two_f(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic icache_addr_fields_t addr_fields_f(input int num_blocks,
                                                          input int block_size,
                                                          input int num_sets);
        icache_addr_fields_t f;
        f.ofs_w = index_size_f(block_size / 4);
        f.idx_w = index_size_f(num_blocks / ((num_sets > 0) ? num_sets : 1));
        f.tag_w = 32 - f.ofs_w - f.idx_w - 2;
        return f;
    endfunction

endpackage

// File: rtl/cellrv32_icache_mem_set.sv
// One cache way: tag array, valid flags, {status, data} word array and the
// registered lookup path feeding the tag comparator.
module cellrv32_icache_mem_set
    import cellrv32_icache_mem_pkg::*;
#(
    parameter int TAG_W = 24,
    parameter int IDX_W = 2,
    parameter int OFS_W = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             invalidate_i,
    input  logic             sel_i,
    input  logic [TAG_W-1:0] acc_tag_i,
    input  logic [TAG_W-1:0] acc_tag_q_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [OFS_W-1:0] ofs_i,
    input  logic             we_i,
    input  logic [32:0]      wword_i,
    input  logic             tag_we_i,
    input  logic             valid_i,
    input  logic             invalid_i,
    output logic             hit_o,
    output logic [32:0]      rword_o
);

    typedef logic [TAG_W-1:0] tag_mem_t [2**IDX_W];
    typedef logic [2**IDX_W-1:0] valid_t;
    typedef logic [32:0] word_mem_t [2**(IDX_W+OFS_W)];

    tag_mem_t         tag_mem;
    valid_t           valid;
    word_mem_t        word_mem;
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;

    // Storage arrays carry no reset; only the valid flags qualify their content.
    always_ff @(posedge clk_i) begin
        if (sel_i && we_i) begin
            word_mem[{idx_i, ofs_i}] <= wword_i;
        end
        if (sel_i && tag_we_i) begin
            tag_mem[idx_i] <= acc_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid <= '0;
        end else if (invalidate_i) begin
            valid <= '0;
        end else if (sel_i) begin
            if (invalid_i) begin
                valid[idx_i] <= 1'b0;
            end else if (valid_i) begin
                valid[idx_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            rword_o <= '0;
        end else begin
            valid_q <= valid[idx_i];
            tag_q   <= tag_mem[idx_i];
            rword_o <= word_mem[{idx_i, ofs_i}];
        end
    end

    assign hit_o = valid_q && (tag_q == acc_tag_q_i);

endmodule

// File: rtl/cellrv32_icache_mem.sv
// Instruction-cache storage core: address mux, ways, 2-way LRU history and output mux.
// Optional macro ICACHE_MEM_SVA_EN enables simulation-only protocol assertions.
module cellrv32_icache_mem
    import cellrv32_icache_mem_pkg::*;
#(
    parameter int ICACHE_NUM_BLOCKS = 4,
    parameter int ICACHE_BLOCK_SIZE = 64,
    parameter int ICACHE_NUM_SETS   = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        invalidate_i,
    input  logic [31:0] host_addr_i,
    input  logic        host_re_i,
    output logic [31:0] host_rdata_o,
    output logic        host_rstat_o,
    output logic        hit_o,
    input  logic        ctrl_en_i,
    input  logic [31:0] ctrl_addr_i,
    input  logic        ctrl_we_i,
    input  logic [31:0] ctrl_wdata_i,
    input  logic        ctrl_wstat_i,
    input  logic        ctrl_tag_we_i,
    input  logic        ctrl_valid_i,
    input  logic        ctrl_invalid_i
);

    localparam icache_addr_fields_t FIELDS =
        addr_fields_f(ICACHE_NUM_BLOCKS, ICACHE_BLOCK_SIZE, ICACHE_NUM_SETS);
    localparam int OFS   = FIELDS.ofs_w;
    localparam int IDX   = FIELDS.idx_w;
    localparam int TAG   = FIELDS.tag_w;
    localparam int OFS_W = (OFS > 0) ? OFS : 1;
    localparam int IDX_W = (IDX > 0) ? IDX : 1;
    localparam int SETS  = (ICACHE_NUM_SETS == 2) ? 2 : 1;

    if (!is_power_of_two_f(ICACHE_NUM_BLOCKS)) begin : g_bad_blocks
        $error("ICACHE_NUM_BLOCKS must be a power of two");
    end
    if (!is_power_of_two_f(ICACHE_BLOCK_SIZE) || (ICACHE_BLOCK_SIZE < 4)) begin : g_bad_bsize
        $error("ICACHE_BLOCK_SIZE must be a power of two >= 4");
    end
    if ((ICACHE_NUM_SETS != 1) && (ICACHE_NUM_SETS != 2)) begin : g_bad_sets
        $error("ICACHE_NUM_SETS must be 1 or 2");
    end

    logic [31:0]      acc_addr;
    logic [TAG-1:0]   acc_tag;
    logic [TAG-1:0]   acc_tag_q;
    logic [IDX_W-1:0] acc_idx;
    logic [OFS_W-1:0] acc_ofs;
    logic [SETS-1:0]  hit_set;
    logic [SETS-1:0]  set_sel;
    logic [32:0]      rword [SETS];
    logic [32:0]      rword_sel;

    assign acc_addr = ctrl_en_i ? ctrl_addr_i : host_addr_i;
    assign acc_tag  = acc_addr[31 -: TAG];

    if (IDX > 0) begin : g_idx
        assign acc_idx = acc_addr[2+OFS +: IDX_W];
    end else begin : g_no_idx
        assign acc_idx = '0;
    end

    if (OFS > 0) begin : g_ofs
        assign acc_ofs = acc_addr[2 +: OFS_W];
    end else begin : g_no_ofs
        assign acc_ofs = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_tag_q <= '0;
        end else begin
            acc_tag_q <= acc_tag;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        cellrv32_icache_mem_set #(
            .TAG_W(TAG),
            .IDX_W(IDX_W),
            .OFS_W(OFS_W)
        ) u_set (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .invalidate_i(invalidate_i),
            .sel_i       (set_sel[s]),
            .acc_tag_i   (acc_tag),
            .acc_tag_q_i (acc_tag_q),
            .idx_i       (acc_idx),
            .ofs_i       (acc_ofs),
            .we_i        (ctrl_we_i),
            .wword_i     ({ctrl_wstat_i, ctrl_wdata_i}),
            .tag_we_i    (ctrl_tag_we_i),
            .valid_i     (ctrl_valid_i),
            .invalid_i   (ctrl_invalid_i),
            .hit_o       (hit_set[s]),
            .rword_o     (rword[s])
        );
    end

    if (SETS == 2) begin : g_lru
        logic [2**IDX_W-1:0] last_used;
        logic                re_ff;
        logic [IDX_W-1:0]    acc_idx_q;

        // A cleared history bit points refills at set 1 first.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                last_used <= '0;
                re_ff     <= 1'b0;
                acc_idx_q <= '0;
            end else begin
                re_ff     <= host_re_i;
                acc_idx_q <= acc_idx;
                if (invalidate_i) begin
                    last_used <= '0;
                end else if (re_ff && hit_o && !ctrl_en_i) begin
                    last_used[acc_idx_q] <= hit_set[1];
                end
            end
        end

        assign set_sel   = ctrl_en_i ? (last_used[acc_idx] ? 2'b01 : 2'b10) : hit_set;
        assign rword_sel = hit_set[1] ? rword[1] : rword[0];
    end else begin : g_dm
        assign set_sel   = ctrl_en_i ? 1'b1 : hit_set;
        assign rword_sel = rword[0];
    end

    assign hit_o        = |hit_set;
    assign host_rdata_o = rword_sel[31:0];
    assign host_rstat_o = rword_sel[32];

`ifdef ICACHE_MEM_SVA_EN
    a_ctrl_only: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !ctrl_en_i |-> !(ctrl_we_i || ctrl_tag_we_i || ctrl_valid_i || ctrl_invalid_i))
        else $error("cache write strobe while ctrl_en_i is low");

    a_hit_known: assert property (@(posedge clk_i) disable iff (!rstn_i) !$isunknown(hit_o))
        else $error("hit_o is unknown after reset");

    if (SETS == 2) begin : g_sva_multi
        a_single_hit: assert property (@(posedge clk_i) disable iff (!rstn_i)
            !(hit_set[0] && hit_set[1]))
            else $error("both sets hit the same address");
    end
`endif

endmodule

// File: tb/tb_cellrv32_icache_mem.sv
// Self-checking bench: a direct-mapped and a 2-way instance share all stimulus.
module tb_cellrv32_icache_mem;

    typedef logic [32:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        invalidate_i;
    logic [31:0] host_addr_i;
    logic        host_re_i;
    logic        ctrl_en_i;
    logic [31:0] ctrl_addr_i;
    logic        ctrl_we_i;
    logic [31:0] ctrl_wdata_i;
    logic        ctrl_wstat_i;
    logic        ctrl_tag_we_i;
    logic        ctrl_valid_i;
    logic        ctrl_invalid_i;

    logic [31:0] rdata1, rdata2;
    logic        rstat1, rstat2, hit1, hit2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cellrv32_icache_mem #(
        .ICACHE_NUM_BLOCKS(4), .ICACHE_BLOCK_SIZE(64), .ICACHE_NUM_SETS(1)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .invalidate_i(invalidate_i),
        .host_addr_i(host_addr_i), .host_re_i(host_re_i),
        .host_rdata_o(rdata1), .host_rstat_o(rstat1), .hit_o(hit1),
        .ctrl_en_i(ctrl_en_i), .ctrl_addr_i(ctrl_addr_i), .ctrl_we_i(ctrl_we_i),
        .ctrl_wdata_i(ctrl_wdata_i), .ctrl_wstat_i(ctrl_wstat_i),
        .ctrl_tag_we_i(ctrl_tag_we_i), .ctrl_valid_i(ctrl_valid_i),
        .ctrl_invalid_i(ctrl_invalid_i)
    );

    cellrv32_icache_mem #(
        .ICACHE_NUM_BLOCKS(4), .ICACHE_BLOCK_SIZE(64), .ICACHE_NUM_SETS(2)
    ) dut2 (
        .clk_i(clk), .rstn_i(rstn_i), .invalidate_i(invalidate_i),
        .host_addr_i(host_addr_i), .host_re_i(host_re_i),
        .host_rdata_o(rdata2), .host_rstat_o(rstat2), .hit_o(hit2),
        .ctrl_en_i(ctrl_en_i), .ctrl_addr_i(ctrl_addr_i), .ctrl_we_i(ctrl_we_i),
        .ctrl_wdata_i(ctrl_wdata_i), .ctrl_wstat_i(ctrl_wstat_i),
        .ctrl_tag_we_i(ctrl_tag_we_i), .ctrl_valid_i(ctrl_valid_i),
        .ctrl_invalid_i(ctrl_invalid_i)
    );

    function automatic blk_t pattern_f(input logic [31:0] base, input logic [31:0] err_addr);
        blk_t b;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] a;
            a = base + 32'(4 * w);
            b[w] = {(a == err_addr), a ^ 32'hA5A5A5A5};
        end
        return b;
    endfunction

    task automatic idle_inputs();
        invalidate_i   = 1'b0;
        host_re_i      = 1'b0;
        ctrl_en_i      = 1'b0;
        ctrl_we_i      = 1'b0;
        ctrl_wdata_i   = '0;
        ctrl_wstat_i   = 1'b0;
        ctrl_tag_we_i  = 1'b0;
        ctrl_valid_i   = 1'b0;
        ctrl_invalid_i = 1'b0;
    endtask

    task automatic refill(input logic [31:0] base, input blk_t words);
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            ctrl_en_i     = 1'b1;
            ctrl_addr_i   = base + 32'(4 * w);
            ctrl_we_i     = 1'b1;
            ctrl_wdata_i  = words[w][31:0];
            ctrl_wstat_i  = words[w][32];
            ctrl_tag_we_i = (w == 15);
            ctrl_valid_i  = (w == 15);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic lookup(input logic [31:0] a, input logic re,
                          output logic h1, output logic [31:0] d1, output logic s1,
                          output logic h2, output logic [31:0] d2);
        @(negedge clk);
        ctrl_en_i   = 1'b0;
        host_addr_i = a;
        host_re_i   = re;
        @(posedge clk);
        #1;
        h1 = hit1; d1 = rdata1; s1 = rstat1;
        h2 = hit2; d2 = rdata2;
        host_re_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic pulse_invalidate();
        @(negedge clk);
        invalidate_i = 1'b1;
        @(negedge clk);
        invalidate_i = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        host_addr_i = '0;
        ctrl_addr_i = '0;
        rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        rstn_i = 1'b1;
        idle_inputs();
        host_addr_i = '0;
        ctrl_addr_i = '0;
        @(negedge clk);
        rstn_i = 1'b0;
        #1;
        n_cmp++; if (hit1 !== 1'b0) begin n_fail++; $display("FAIL reset_hit1 got %b want 0", hit1); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
        n_cmp++; if (rstat1 !== 1'b0) begin n_fail++; $display("FAIL reset_rstat1 got %b want 0", rstat1); end
        n_cmp++; if (hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_hit2 got %b want 0", hit2); end
        n_cmp++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 got %h want 0", rdata2); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        lookup(32'h0000_0040, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL cold_miss got %b want 0", h1); end
        n_cmp++; if (h2 !== 1'b0) begin n_fail++; $display("FAIL cold_miss_2way got %b want 0", h2); end
    endtask

    task automatic test_refill();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        refill(32'h100, pattern_f(32'h100, 32'hFFFF_FFFF));
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL refill_hit got %b want 1", h1); end
        n_cmp++; if (d1 !== 32'hA5A5A4AD) begin n_fail++; $display("FAIL refill_data got %h want a5a5a4ad", d1); end
        n_cmp++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL refill_rstat got %b want 0", s1); end
        lookup(32'h13C, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (d1 !== 32'hA5A5A499) begin n_fail++; $display("FAIL refill_last_word got %h want a5a5a499", d1); end
    endtask

    task automatic test_error_status();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        refill(32'h100, pattern_f(32'h100, 32'h104));
        lookup(32'h104, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL err_hit got %b want 1", h1); end
        n_cmp++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL err_rstat got %b want 1", s1); end
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL err_neighbour_rstat got %b want 0", s1); end
    endtask

    task automatic test_invalidate();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        refill(32'h100, pattern_f(32'h100, 32'hFFFF_FFFF));
        pulse_invalidate();
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL inval_all got %b want 0", h1); end
        refill(32'h100, pattern_f(32'h100, 32'hFFFF_FFFF));
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL inval_refill got %b want 1", h1); end
        @(negedge clk);
        ctrl_en_i      = 1'b1;
        ctrl_addr_i    = 32'h100;
        ctrl_invalid_i = 1'b1;
        ctrl_valid_i   = 1'b1;
        @(negedge clk);
        idle_inputs();
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL inval_line got %b want 0", h1); end
    endtask

    task automatic test_conflict();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        refill(32'h100, pattern_f(32'h100, 32'hFFFF_FFFF));
        lookup(32'h1100, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL conflict_miss got %b want 0", h1); end
        refill(32'h1100, pattern_f(32'h1100, 32'hFFFF_FFFF));
        lookup(32'h1108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL conflict_new_hit got %b want 1", h1); end
        n_cmp++; if (d1 !== 32'hA5A5B4AD) begin n_fail++; $display("FAIL conflict_new_data got %h want a5a5b4ad", d1); end
        lookup(32'h108, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL conflict_evicted got %b want 0", h1); end
    endtask

    // Reference: each line holds at most one resident block; words kept by byte address.
    task automatic test_random();
        logic [23:0] tags [4];
        logic [31:0] res_blk [4];
        bit          res_vld [4];
        logic [32:0] model [logic [31:0]];
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        tags[0] = 24'h000001; tags[1] = 24'h000011; tags[2] = 24'hFFFFFF; tags[3] = 24'h800000;
        apply_reset();
        for (int i = 0; i < 4; i++) res_vld[i] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            int li;
            int op;
            logic [31:0] blk;
            li  = $urandom_range(0, 3);
            op  = $urandom_range(0, 9);
            blk = {tags[$urandom_range(0, 3)], 2'(li), 6'b0};
            if (op < 3) begin
                blk_t words;
                for (int w = 0; w < 16; w++) begin
                    words[w] = {1'($urandom_range(0, 1)), 32'($urandom)};
                    model[blk + 32'(4 * w)] = words[w];
                end
                refill(blk, words);
                res_blk[li] = blk;
                res_vld[li] = 1'b1;
            end else if (op == 3) begin
                pulse_invalidate();
                for (int i = 0; i < 4; i++) res_vld[i] = 1'b0;
            end else begin
                logic [31:0] a;
                logic        exp_hit;
                a = blk + 32'(4 * $urandom_range(0, 15));
                exp_hit = res_vld[li] && (res_blk[li] == blk);
                lookup(a, 1'b0, h1, d1, s1, h2, d2);
                n_cmp++;
                if (h1 !== exp_hit) begin
                    n_fail++; $display("FAIL rand_hit addr %h got %b want %b", a, h1, exp_hit);
                end
                if (exp_hit) begin
                    n_cmp++;
                    if ({s1, d1} !== model[a]) begin
                        n_fail++; $display("FAIL rand_word addr %h got %h want %h", a, {s1, d1}, model[a]);
                    end
                end
            end
        end
    endtask

    task automatic test_lru();
        logic h1, s1, h2;
        logic [31:0] d1, d2;
        apply_reset();
        refill(32'h000, pattern_f(32'h000, 32'hFFFF_FFFF));
        lookup(32'h000, 1'b1, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b1) begin n_fail++; $display("FAIL lru_first_hit got %b want 1", h2); end
        n_cmp++; if (d2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lru_first_data got %h want a5a5a5a5", d2); end
        refill(32'h080, pattern_f(32'h080, 32'hFFFF_FFFF));
        lookup(32'h084, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b1) begin n_fail++; $display("FAIL lru_second_hit got %b want 1", h2); end
        n_cmp++; if (d2 !== 32'hA5A5A521) begin n_fail++; $display("FAIL lru_second_data got %h want a5a5a521", d2); end
        lookup(32'h000, 1'b1, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b1) begin n_fail++; $display("FAIL lru_both_resident got %b want 1", h2); end
        refill(32'h100, pattern_f(32'h100, 32'hFFFF_FFFF));
        lookup(32'h000, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b1) begin n_fail++; $display("FAIL lru_mru_kept got %b want 1", h2); end
        lookup(32'h080, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b0) begin n_fail++; $display("FAIL lru_victim_gone got %b want 0", h2); end
        lookup(32'h100, 1'b1, h1, d1, s1, h2, d2);
        n_cmp++; if (d2 !== 32'hA5A5A4A5) begin n_fail++; $display("FAIL lru_third_data got %h want a5a5a4a5", d2); end
        refill(32'h180, pattern_f(32'h180, 32'hFFFF_FFFF));
        lookup(32'h000, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b0) begin n_fail++; $display("FAIL lru_set1_evicted got %b want 0", h2); end
        lookup(32'h188, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (d2 !== 32'hA5A5A42D || h2 !== 1'b1) begin
            n_fail++; $display("FAIL lru_fourth got hit %b data %h want 1 a5a5a42d", h2, d2);
        end
        lookup(32'h100, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b1) begin n_fail++; $display("FAIL lru_set0_kept got %b want 1", h2); end
        pulse_invalidate();
        lookup(32'h100, 1'b0, h1, d1, s1, h2, d2);
        n_cmp++; if (h2 !== 1'b0) begin n_fail++; $display("FAIL lru_invalidate got %b want 0", h2); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_error_status();
        test_invalidate();
        test_conflict();
        test_random();
        test_lru();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cellrv32_icache_mem.md
Name: cellrv32_icache_mem

Overview:
Storage and lookup core of the processor-internal instruction cache: tag memory, valid flags, data/status memory, hit comparator and the 2-way LRU history. The cache controller FSM drives it. Host side is a read-only lookup with 1-cycle latency. Control side is write-only and is used for block refill and invalidation.

Parameters:
ICACHE_NUM_BLOCKS, 4, total number of blocks across all sets; power of 2, >=1.
ICACHE_BLOCK_SIZE, 64, block size in bytes; power of 2, >=4.
ICACHE_NUM_SETS, 1, associativity; 1 = direct-mapped, 2 = 2-way; any other value is an elaboration error.

Derived widths:
- OFS = log2(BLOCK_SIZE/4).
- IDX = log2(NUM_BLOCKS/NUM_SETS).
- TAG = 32 - OFS - IDX - 2.
- Address fields: tag = [31 -: TAG]; index = [2+OFS +: IDX]; word offset = [2 +: OFS].

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
invalidate_i  in  1  clear all valid flags and LRU history
host_addr_i  in  32  lookup address
host_re_i  in  1  host read strobe (used for LRU update)
host_rdata_o  out  32  read data (1 cycle after address)
host_rstat_o  out  1  stored bus-error status of the read word
hit_o  out  1  hit for the address presented in the previous cycle
ctrl_en_i  in  1  control mode; index/offset come from ctrl_addr_i
ctrl_addr_i  in  32  refill address
ctrl_we_i  in  1  write ctrl_wdata_i/ctrl_wstat_i to the selected word
ctrl_wdata_i  in  32  refill data
ctrl_wstat_i  in  1  refill error status
ctrl_tag_we_i  in  1  write tag of ctrl_addr_i to the selected set/index
ctrl_valid_i  in  1  set valid flag of the selected set/index
ctrl_invalid_i  in  1  clear valid flag of the selected set/index

Behaviour:
Reset (async, rstn_i=0):
- Valid flags, LRU history and all output registers cleared.
- hit_o=0, host_rdata_o=0, host_rstat_o=0.
- Tag and data arrays are not reset.

Address mux: ctrl_en_i=1 selects ctrl_addr_i fields; otherwise host_addr_i fields.

Lookup (every cycle, independent of host_re_i):
- Per set, register valid[idx], tag[idx] and data/status word[idx,ofs]; also register the access tag.
- Next cycle: hit_s = valid_s && tag_s == access tag; hit_o = OR of hit_s.
- host_rdata_o/host_rstat_o come from the hitting set; set 0 is used when no set hits.
- Direct-mapped: only set 0 exists.

Data word storage: 33 bits per word, {status, data}.

Set selection:
- ctrl_en_i=1: the replacement set. This is !last_used[idx] when NUM_SETS=2, else set 0.
- ctrl_en_i=0: the hitting set.

Write priorities, per clock, for the selected set:
- ctrl_we_i writes the data word.
- ctrl_tag_we_i writes the tag.
- ctrl_valid_i sets the valid flag; ctrl_invalid_i clears it. If both are asserted, invalid wins.
- invalidate_i clears all valid flags of all sets and has priority over ctrl_valid_i.

LRU (NUM_SETS=2 only):
- Register host_re_i as re_ff.
- When re_ff && hit_o && !ctrl_en_i: last_used[registered idx] <= hit set.
- invalidate_i clears all history to 0, so set 1 is replaced first.

Read-after-write: a word written in cycle N is readable by a lookup in cycle N+1 and appears on the outputs in N+2. This matches the controller's two re-sync cycles.

Optional Feature:
ICACHE_MEM_SVA_EN
- Defined: simulation-only concurrent assertions fire $error when any of these holds:
  - ctrl_we_i, ctrl_tag_we_i, ctrl_valid_i or ctrl_invalid_i asserted while ctrl_en_i=0;
  - both sets hit the same address;
  - hit_o is X after reset.
- Undefined: no assertions; RTL is functionally identical.

Decomposition:
- The shared package holds index_size_f, is_power_of_two_f and the address-field struct.
- Local typedefs: tag array, valid vector and 33-bit word array.
- One sub-module, cellrv32_icache_mem_set, holds the tag, valid and data arrays plus the comparator for one way. It is instantiated NUM_SETS times.
- The top level holds the address mux, LRU history and output mux.

Test Plan:
1. Reset, then lookup at 0x0000_0040 -> hit_o=0 next cycle.
2. Refill 0x100..0x13C (default params):
   - stimulus: ctrl_en=1; 16 writes of data=addr^0xA5A5A5A5; tag_we and valid on the last word;
   - response: host lookup 0x108 -> hit_o=1, host_rdata_o=0xA5A5A4AD, rstat=0.
3. Refill with ctrl_wstat_i=1 on word 0x104 -> lookup 0x104 gives hit_o=1, host_rstat_o=1.
4. After test 2, pulse invalidate_i -> lookup 0x108 gives hit_o=0. Also, ctrl_invalid_i on index 0 gives a miss.
5. Conflict miss: after test 2, lookup 0x1100 (same index, other tag) -> hit_o=0. With NUM_SETS=1, refill 0x1100 evicts 0x100.
6. NUM_SETS=2, NUM_BLOCKS=4: fill 0x000 (set 1), then fill 0x080 (set 0), then read 0x000 with re -> fill 0x100 replaces 0x080; 0x000 still hits.
